// File: rtl/shift_seq_32.sv
// shift_seq_32: sequencer that turns a one-cycle shift request into a series of
// single-bit 74LS194-style commands for shift_32. It loads the operand, shifts
// once per clock for amt cycles, and then captures the final word from Q.
module shift_seq_32 (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic        dir,
    input  logic [1:0]  mode,
    input  logic [4:0]  amt,
    input  logic [31:0] din,
    input  logic [31:0] Q,
    output logic        S1,
    output logic        S0,
    output logic        SL,
    output logic        SR,
    output logic [31:0] PData,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] SHIFT   = 2'd2;
    localparam logic [1:0] DONE_ST = 2'd3;

    localparam logic [1:0] M_ARITH  = 2'b01;
    localparam logic [1:0] M_ROTATE = 2'b10;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        dir_r;
    logic [1:0]  mode_r;
    logic [31:0] data_r;

    // Sequencer state, request capture, shift counter and result capture
    always_ff @(posedge clk) begin
        if (clear) begin
            state  <= IDLE;
            cnt    <= '0;
            dir_r  <= 1'b0;
            mode_r <= '0;
            data_r <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_r  <= dir;
                        mode_r <= mode;
                        cnt    <= amt;
                        data_r <= din;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    state <= (cnt == 5'd0) ? DONE_ST : SHIFT;
                end
                SHIFT: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= DONE_ST;
                    end
                end
                DONE_ST: begin
                    result <= Q;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore decode of shift_32 mode pins and status flags
    always_comb begin
        S1   = 1'b0;
        S0   = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            LOAD: begin
                S1   = 1'b1;
                S0   = 1'b1;
                busy = 1'b1;
            end
            SHIFT: begin
                S1   = ~dir_r;
                S0   = dir_r;
                busy = 1'b1;
            end
            DONE_ST: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                S1 = 1'b0;
                S0 = 1'b0;
            end
        endcase
    end

    // Serial fill bits; the side not being shifted into is held at 0
    always_comb begin
        SL = 1'b0;
        SR = 1'b0;
        if (dir_r) begin
            if (mode_r == M_ARITH) begin
                SR = Q[31];
            end else if (mode_r == M_ROTATE) begin
                SR = Q[0];
            end
        end else begin
            if (mode_r == M_ROTATE) begin
                SL = Q[31];
            end
        end
    end

    assign PData = data_r;

endmodule

// File: tb/tb_shift_seq_32.sv
// tb_shift_seq_32: exercises shift_seq_32 against a behavioural shift_32
// register and an arithmetic reference model of the requested shift.
module tb_shift_seq_32;

    logic        clk = 1'b0;
    logic        clear, start, dir;
    logic [1:0]  mode;
    logic [4:0]  amt;
    logic [31:0] din, Q;
    logic        S1, S0, SL, SR, busy, done;
    logic [31:0] PData, result;

    int errors = 0;
    int checks = 0;

    shift_seq_32 dut (
        .clk(clk), .clear(clear), .start(start), .dir(dir), .mode(mode),
        .amt(amt), .din(din), .Q(Q), .S1(S1), .S0(S0), .SL(SL), .SR(SR),
        .PData(PData), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Behavioural 74LS194-style 32-bit register standing in for shift_32
    always @(posedge clk) begin
        if (clear) Q <= '0;
        else case ({S1, S0})
            2'b01:   Q <= {SR, Q[31:1]};
            2'b10:   Q <= {Q[30:0], SL};
            2'b11:   Q <= PData;
            default: Q <= Q;
        endcase
    end

    // Reference: the whole multi-bit shift in one step
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic dr,
                                              input logic [1:0] m, input int unsigned n);
        logic [63:0] t;
        t = {d, d};
        if (m == 2'b10) begin
            if (dr) begin t = t >> n; return t[31:0]; end
            else    begin t = t << n; return t[63:32]; end
        end
        if (m == 2'b01 && dr) return 32'($signed(d) >>> n);
        return dr ? (d >> n) : (d << n);
    endfunction

    // Drives one request and observes it; inj_edge >= 0 pulses a conflicting
    // start during the run. Edge index 0 is the cycle right after the start edge.
    task automatic run_req(input logic [31:0] d, input logic dr, input logic [1:0] m,
                           input logic [4:0] n, input int inj_edge,
                           output int done_at, output int busy_cyc, output int ndone,
                           output logic [31:0] res, output logic tmo);
        int e;
        @(negedge clk);
        din = d; dir = dr; mode = m; amt = n; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        din = $urandom; dir = 1'($urandom); mode = 2'($urandom); amt = 5'($urandom);
        done_at = -1; busy_cyc = 0; ndone = 0; tmo = 1'b1; e = 0;
        while (e < 45) begin
            if (busy) busy_cyc++;
            if (done) begin ndone++; if (done_at < 0) done_at = e; end
            if (!busy) begin tmo = 1'b0; break; end
            if (e == inj_edge) begin
                start = 1'b1; din = ~d; dir = ~dr; mode = 2'b10; amt = 5'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            e++;
        end
        start = 1'b0;
        res = result;
    endtask

    task automatic check_req(input string name, input logic [31:0] d, input logic dr,
                             input logic [1:0] m, input logic [4:0] n, input int inj);
        int da, bc, nd; logic [31:0] r, exp; logic tmo;
        exp = ref_shift(d, dr, m, int'(n));
        run_req(d, dr, m, n, inj, da, bc, nd, r, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL %s timeout: busy never dropped", name); end
        checks++;
        if (r !== exp) begin errors++; $display("FAIL %s result: got %h expected %h", name, r, exp); end
        checks++;
        if (da !== int'(n) + 1) begin errors++; $display("FAIL %s done timing: got edge %0d expected %0d", name, da, int'(n) + 1); end
        checks++;
        if (bc !== int'(n) + 2) begin errors++; $display("FAIL %s busy length: got %0d expected %0d", name, bc, int'(n) + 2); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL %s done count: got %0d expected 1", name, nd); end
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; din = '0; dir = 1'b0; mode = '0; amt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({S1, S0, SL, SR, busy, done} !== 6'b0 || PData !== '0 || result !== '0) begin
            errors++;
            $display("FAIL reset outputs: S1S0SLSR=%b%b%b%b busy=%b done=%b PData=%h result=%h expected all 0",
                     S1, S0, SL, SR, busy, done, PData, result);
        end
        clear = 1'b0;
    endtask

    task automatic test_directed();
        check_req("lsr",        32'h80000001, 1'b1, 2'b00, 5'd4,  -1);
        checks++;
        if (result !== 32'h08000000) begin errors++; $display("FAIL lsr const: got %h expected 08000000", result); end
        check_req("asr",        32'hF0000000, 1'b1, 2'b01, 5'd8,  -1);
        checks++;
        if (result !== 32'hFFF00000) begin errors++; $display("FAIL asr const: got %h expected fff00000", result); end
        check_req("asl",        32'h40000001, 1'b0, 2'b01, 5'd1,  -1);
        checks++;
        if (result !== 32'h80000002) begin errors++; $display("FAIL asl const: got %h expected 80000002", result); end
        check_req("rol",        32'h80000001, 1'b0, 2'b10, 5'd1,  -1);
        checks++;
        if (result !== 32'h00000003) begin errors++; $display("FAIL rol const: got %h expected 00000003", result); end
        check_req("ror31",      32'h12345678, 1'b1, 2'b10, 5'd31, -1);
        checks++;
        if (result !== 32'h2468ACF0) begin errors++; $display("FAIL ror31 const: got %h expected 2468acf0", result); end
        check_req("amt0",       32'hDEADBEEF, 1'b0, 2'b00, 5'd0,  -1);
        checks++;
        if (result !== 32'hDEADBEEF) begin errors++; $display("FAIL amt0 const: got %h expected deadbeef", result); end
        check_req("mode11",     32'hFFFFFFFF, 1'b0, 2'b11, 5'd31, -1);
        checks++;
        if (result !== 32'h80000000) begin errors++; $display("FAIL mode11 const: got %h expected 80000000", result); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            check_req("random", $urandom, 1'($urandom), 2'($urandom), 5'($urandom), -1);
        end
    endtask

    task automatic test_back_to_back();
        check_req("ignored_start", 32'hA5A5F00F, 1'b1, 2'b01, 5'd10, 4);
        check_req("after_ignore",  32'h0F0F1234, 1'b0, 2'b10, 5'd7,  -1);
    endtask

    task automatic test_clear_mid();
        int nd; logic [31:0] prev;
        prev = result;
        @(negedge clk);
        din = 32'h13579BDF; dir = 1'b1; mode = 2'b00; amt = 5'd20; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if ({S1, S0, SL, SR, busy, done} !== 6'b0 || PData !== '0 || result !== '0 || Q !== '0) begin
            errors++;
            $display("FAIL clear_mid outputs: S1S0SLSR=%b%b%b%b busy=%b done=%b PData=%h result=%h Q=%h expected 0 (prev result %h)",
                     S1, S0, SL, SR, busy, done, PData, result, Q, prev);
        end
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            if (done) nd++;
            @(negedge clk);
        end
        checks++;
        if (nd !== 0) begin errors++; $display("FAIL clear_mid done after clear: got %0d expected 0", nd); end
        check_req("after_clear", 32'hC0FFEE01, 1'b1, 2'b10, 5'd9, -1);
    endtask

    task automatic test_clear_wins();
        @(negedge clk);
        din = 32'h11111111; dir = 1'b0; mode = 2'b00; amt = 5'd2; start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || PData !== '0) begin
            errors++; $display("FAIL clear_wins: busy=%b PData=%h expected 0 and 00000000", busy, PData);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_clear_mid();
        test_clear_wins();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
